multi_debouncer: RTL and testbench

MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

---
 rtl/multi_debouncer.sv | 125 ++++++++++++
 tb/tb_multi_debouncer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_debouncer.sv
// Multi-channel debouncer: 2-flop synchroniser, 2^CNT_W-cycle stability counter, edge pulses.
// Define MULTI_DEBOUNCER_AUTOREPEAT_EN to build the per-channel auto-repeat generator.
module multi_debouncer #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 17,
  parameter int RPT_FIRST  = 50000000,
  parameter int RPT_PERIOD = 10000000
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [N_CH-1:0] i_signal,
  output logic [N_CH-1:0] o_state,
  output logic [N_CH-1:0] o_trans_up,
  output logic [N_CH-1:0] o_trans_dn,
  output logic [N_CH-1:0] o_repeat,
  output logic            o_busy
);

  localparam bit RPT_CFG_OK = (RPT_FIRST >= 2) && (RPT_PERIOD >= 2) && (RPT_PERIOD <= RPT_FIRST);

  logic [N_CH-1:0] s0_q;
  logic [N_CH-1:0] s1_q;
  logic [N_CH-1:0] state_q;
  logic [N_CH-1:0] state_d;
  logic [N_CH-1:0] trans_up_q;
  logic [N_CH-1:0] trans_dn_q;
  logic [N_CH-1:0] mismatch;
  logic [N_CH-1:0] flip;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s0_q <= '0;
      s1_q <= '0;
    end else begin
      s0_q <= i_signal;
      s1_q <= s0_q;
    end
  end

  assign mismatch = s1_q ^ state_q;
  assign state_d  = state_q ^ flip;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_chan
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // The counter only runs while the synchronised input disagrees with the output.
      assign flip[gi] = mismatch[gi] && (cnt_q == {CNT_W{1'b1}});

      always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!mismatch[gi] || flip[gi]) begin
          cnt_d = '0;
        end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= '0;
      trans_up_q <= '0;
      trans_dn_q <= '0;
    end else begin
      state_q    <= state_d;
      trans_up_q <= flip & ~state_q;
      trans_dn_q <= flip & state_q;
    end
  end

  assign o_state    = state_q;
  assign o_trans_up = trans_up_q;
  assign o_trans_dn = trans_dn_q;
  assign o_busy     = |mismatch;

  generate
    if (!RPT_CFG_OK) begin : g_rpt_cfg_invalid
    end
  endgenerate

`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
  localparam int RPT_W = (RPT_FIRST > 2) ? $clog2(RPT_FIRST) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(RPT_FIRST - 1);
  localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(RPT_FIRST - RPT_PERIOD);

  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_rpt
      logic [RPT_W-1:0] rpt_cnt_q;
      logic             rpt_q;

      // After each pulse the counter reloads so the next one lands RPT_PERIOD cycles later.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          rpt_cnt_q <= '0;
          rpt_q     <= 1'b0;
        end else if (!state_q[gi] || flip[gi]) begin
          rpt_cnt_q <= '0;
          rpt_q     <= 1'b0;
        end else if (rpt_cnt_q == RPT_LAST) begin
          rpt_cnt_q <= RPT_RELOAD;
          rpt_q     <= 1'b1;
        end else begin
          rpt_cnt_q <= rpt_cnt_q + 1'b1;
          rpt_q     <= 1'b0;
        end
      end

      assign o_repeat[gi] = rpt_q;
    end
  endgenerate
`else
  assign o_repeat = '0;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer with a cycle-level reference model checked every cycle.
module tb_multi_debouncer;
  localparam int N_CH   = 4;
  localparam int CNT_W  = 4;
  localparam int RF     = 40;
  localparam int RP     = 10;
  localparam int SETTLE = 2 + (1 << CNT_W);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N_CH-1:0] sig = '0;
  logic [N_CH-1:0] o_state, o_trans_up, o_trans_dn, o_repeat;
  logic            o_busy;

  int n_pass = 0;
  int n_total = 0;

  multi_debouncer #(
    .N_CH(N_CH), .CNT_W(CNT_W), .RPT_FIRST(RF), .RPT_PERIOD(RP)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_signal(sig),
    .o_state(o_state), .o_trans_up(o_trans_up), .o_trans_dn(o_trans_dn),
    .o_repeat(o_repeat), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: input delayed by two samples, then a run-length rule on disagreement.
  logic [N_CH-1:0] m_d1, m_d2, m_st, m_up, m_dn, m_rpt;
  int m_run[N_CH];
  int m_since[N_CH];

  task automatic model_clear();
    m_d1 = '0; m_d2 = '0; m_st = '0; m_up = '0; m_dn = '0; m_rpt = '0;
    for (int k = 0; k < N_CH; k++) begin
      m_run[k] = 0;
      m_since[k] = 0;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_clear();
      end else begin
        for (int k = 0; k < N_CH; k++) begin
          logic changed;
          logic now_high;
          changed = 1'b0;
          if (m_d2[k] != m_st[k]) begin
            m_run[k] = m_run[k] + 1;
            if (m_run[k] == (1 << CNT_W)) begin
              changed = 1'b1;
              m_run[k] = 0;
            end
          end else begin
            m_run[k] = 0;
          end
          now_high = m_st[k] ^ changed;
          m_up[k]  = changed & now_high;
          m_dn[k]  = changed & ~now_high;
          if (now_high && !changed) m_since[k] = m_since[k] + 1;
          else m_since[k] = 0;
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
          m_rpt[k] = now_high && !changed && (m_since[k] >= RF) && (((m_since[k] - RF) % RP) == 0);
`else
          m_rpt[k] = 1'b0;
`endif
          m_st[k] = now_high;
        end
        m_d2 = m_d1;
        m_d1 = sig;
      end
      @(negedge clk);
      if (!rst_n) model_clear();
      check("cmp_state", o_state, m_st);
      check("cmp_up", o_trans_up, m_up);
      check("cmp_dn", o_trans_dn, m_dn);
      check("cmp_repeat", o_repeat, m_rpt);
      check("cmp_busy", o_busy, |(m_d2 ^ m_st));
    end
  end

  // Counts edges until o_state[ch]==val; -1 means the bound expired.
  task automatic measure(input int ch, input logic val, output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (o_state[ch] == val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    sig = '0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int n;
    int pulses;
    int first;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", o_state, 4'h0);
    check("rst_up_dn", {o_trans_up, o_trans_dn}, 8'h00);
    check("rst_busy", o_busy, 1'b0);
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("release_no_pulse", {o_trans_up, o_trans_dn, o_repeat}, 12'h000);

    // single channel rise
    @(posedge clk); #2 sig = 4'b0001;
    measure(0, 1'b1, n);
    check("lat_ch0_rise", n, SETTLE);
    check("ch0_up_pulse", o_trans_up, 4'b0001);
    check("ch0_no_dn", o_trans_dn, 4'b0000);
    @(negedge clk);
    check("ch0_up_one_cycle", o_trans_up, 4'b0000);
    check("ch0_state_held", o_state, 4'b0001);

    // glitchy channel 1
    @(posedge clk); #2 sig = 4'b0011;
    repeat (10) @(posedge clk);
    #2 sig = 4'b0001;
    repeat (3) @(posedge clk);
    #2 check("ch1_no_early_flip", o_state[1], 1'b0);
    sig = 4'b0011;
    measure(1, 1'b1, n);
    check("lat_ch1_after_glitch", n, SETTLE);

    // all channels at once
    pulse_reset();
    @(posedge clk); #2 sig = 4'b1111;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("busy_during_settle", o_busy, 1'b1);
    measure(0, 1'b1, n);
    check("lat_all_rise", n + 10, SETTLE);
    check("all_state", o_state, 4'b1111);
    check("all_up", o_trans_up, 4'b1111);
    check("busy_after_settle", o_busy, 1'b0);

    // channel 2 falls
    @(posedge clk); #2 sig = 4'b1011;
    measure(2, 1'b0, n);
    check("lat_ch2_fall", n, SETTLE);
    check("ch2_dn_pulse", o_trans_dn, 4'b0100);
    check("ch2_no_up", o_trans_up, 4'b0000);
    check("ch2_state", o_state, 4'b1011);

    // reset mid-settle discards progress
    pulse_reset();
    @(posedge clk); #2 sig = 4'b0001;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("midrst_outputs", {o_state, o_trans_up, o_trans_dn, o_repeat, 3'b000, o_busy}, 20'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    measure(0, 1'b1, n);
    check("lat_after_midrst", n, SETTLE);

    // channel 3 held high
    @(posedge clk); #2 sig = 4'b1001;
    measure(3, 1'b1, n);
    check("lat_ch3_rise", n, SETTLE);
    pulses = 0;
    first = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (o_repeat[3]) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
`ifdef MULTI_DEBOUNCER_AUTOREPEAT_EN
    check("rpt_count", pulses, 7);
    check("rpt_first", first, RF);
`else
    check("rpt_count", pulses, 0);
`endif
    @(posedge clk); #2 sig = 4'b0001;
    measure(3, 1'b0, n);
    check("lat_ch3_fall", n, SETTLE);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("rpt_after_release", o_repeat, 4'b0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
